ecall_io_ctrl: RTL and testbench
================================

ECALL_IO_CTRL -- requirements
Module: ecall_io_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 200000, meaning the number of consecutive cycles a synchronized button level must hold before it is accepted (minimum 2).
REQ-002 clock  input  1  the single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 ecall  input  1  high while the fetched instruction equals 32'h00000073.
REQ-005 rega7  input  32  current value of register a7 (service code).
REQ-006 rega0  input  32  current value of register a0 (output data).
REQ-007 switch_in  input  16  board switches, quasi-static.
REQ-008 confirm_btn  input  1  raw, asynchronous, bouncing confirm button; pressed = 1.
REQ-009 stall  output  1  high holds PC and blocks register/memory writes for the current instruction.
REQ-010 io_wen  output  1  one-cycle pulse; writes io_wdata into a0.
REQ-011 io_wdata  output  32  read-service result.
REQ-012 led_out  output  16  registered LED drive.
REQ-013 seg_out  output  32  registered 7-segment display value.

Function
REQ-014 Service codes SHALL be: 0 = switch_in zero-extended; 1 = switch_in sign-extended from bit 15; 2 = switch_in[7:0] zero-extended; 3 = {31'b0, switch_in[0]}; 4 = write led_out; 5 = write seg_out. Any other code SHALL be a no-op: no stall, no io_wen, no register change.
REQ-015 confirm_btn SHALL pass a 2-flop synchronizer, then a debouncer: accepted level changes only after DEBOUNCE_CYCLES consecutive cycles at the new synchronized level; a deviating sample restarts the count.
REQ-016 FSM states SHALL be IDLE, WAIT_PRESS, WAIT_RELEASE, DONE.
REQ-017 IDLE, ecall=1, rega7 in 0..3: stall=1 combinationally that cycle; latch service code; next state WAIT_PRESS.
REQ-018 WAIT_PRESS: stall=1; on first cycle with debounced level = 1, capture the formatted result (REQ-014) from switch_in of that cycle into a data register; next state WAIT_RELEASE.
REQ-019 Debounced level already 1 on entering WAIT_PRESS SHALL NOT count; a fresh 0->1 accepted transition is required.
REQ-020 WAIT_RELEASE: stall=1; on debounced level = 0, next state DONE.
REQ-021 DONE: stall=0, io_wen=1, io_wdata = captured data; unconditional next state IDLE. Exactly one io_wen pulse per read ecall.
REQ-022 io_wdata SHALL be held at the captured value outside DONE; io_wen=0 in every state other than DONE.
REQ-023 IDLE, ecall=1, rega7=4: no stall; led_out <= rega0[15:0] at that clock edge.
REQ-024 IDLE, ecall=1, rega7=5: no stall; seg_out <= rega0 at that clock edge.
REQ-025 Changes of ecall, rega7 or rega0 while not in IDLE SHALL be ignored.
REQ-026 Switch changes after capture in WAIT_PRESS SHALL NOT alter io_wdata.
REQ-027 Latency of a read ecall SHALL be: stalled cycles = 1 (IDLE) + cycles in WAIT_PRESS + cycles in WAIT_RELEASE; commit in DONE.
REQ-028 The debounce counter SHALL saturate at DEBOUNCE_CYCLES and not wrap.

Reset
REQ-029 On reset=1 at a clock edge: state=IDLE, stall=0, io_wen=0, io_wdata=0, led_out=0, seg_out=0, debounced level=0, synchronizer flops=0, debounce counter=0.
REQ-030 Reset asserted in any state, including mid-read, SHALL abort the service with no io_wen pulse; stall is 0 in the cycle after the reset edge.
REQ-031 Outputs SHALL be undefined-free (no X) from the first edge with reset=1.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 rega7=0, switch_in=16'h8001, ecall=1, clean press then release -> stall high from the ecall cycle until DONE; one io_wen pulse, io_wdata=32'h00008001.
REQ-033 rega7=1, switch_in=16'h8001 -> io_wdata=32'hFFFF8001; rega7=2 -> 32'h00000001; rega7=3, switch_in=16'h0002 -> 32'h00000000.
REQ-034 rega7=4, rega0=32'h1234ABCD, ecall=1 for one cycle -> stall never high; led_out=16'hABCD after the edge. rega7=5 -> seg_out=32'h1234ABCD. rega7=9 -> no output change, no stall.
REQ-035 Button toggling every 2 cycles for 20 cycles, then high for 4 -> only one accepted press; capture happens in the cycle the 4th consecutive high sample is counted.
REQ-036 Button held high before the ecall -> no capture until release (>=4 low) and a new press (>=4 high).
REQ-037 reset=1 during WAIT_RELEASE -> next cycle state IDLE, stall=0, io_wen never pulses, led_out and seg_out = 0.

Source files
------------

// File: rtl/ecall_io_ctrl_if.sv
// CPU-side ecall handshake: service request in, stall and a0 write-back out.
interface ecall_io_ctrl_if;
  logic        ecall;
  logic [31:0] rega7;
  logic [31:0] rega0;
  logic        stall;
  logic        io_wen;
  logic [31:0] io_wdata;

  modport master (output ecall, rega7, rega0, input  stall, io_wen, io_wdata);
  modport slave  (input  ecall, rega7, rega0, output stall, io_wen, io_wdata);
endinterface

// File: rtl/ecall_io_ctrl.sv
// Ecall I/O service unit: switch reads gated by a debounced confirm button,
// LED / 7-segment writes completed in a single cycle.
module ecall_io_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
  input  logic            clock,
  input  logic            reset,
  ecall_io_ctrl_if.slave  cpu,
  input  logic [15:0]     switch_in,
  input  logic            confirm_btn,
  output logic [15:0]     led_out,
  output logic [31:0]     seg_out
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          btn_q, btn_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    svc_q, svc_d;
  logic [31:0]   data_q, data_d;
  logic          stall_q, stall_d, wen_q, wen_d;
  logic [15:0]   led_q, led_d;
  logic [31:0]   seg_q, seg_d;
  logic          rd_req, btn_rise;

  function automatic logic [31:0] fmt(input logic [1:0] svc, input logic [15:0] sw);
    case (svc)
      2'd0:    return {16'b0, sw};
      2'd1:    return {{16{sw[15]}}, sw};
      2'd2:    return {24'b0, sw[7:0]};
      default: return {31'b0, sw[0]};
    endcase
  endfunction

  // Count consecutive synchronized samples that disagree with the accepted
  // level; any agreeing sample restarts the run.
  always_comb begin
    sync1_d = confirm_btn;
    sync2_d = sync1_q;
    btn_d   = btn_q;
    cnt_d   = '0;
    cnt_inc = (cnt_q == CW'(DEBOUNCE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
    if (sync2_q != btn_q) begin
      if (cnt_inc == CW'(DEBOUNCE_CYCLES)) btn_d = sync2_q;
      else                                 cnt_d = cnt_inc;
    end
  end

  assign btn_rise = btn_d & ~btn_q;
  assign rd_req   = (state_q == IDLE) && cpu.ecall && (cpu.rega7 < 32'd4);

  always_comb begin
    state_d = state_q;
    svc_d   = svc_q;
    data_d  = data_q;
    led_d   = led_q;
    seg_d   = seg_q;
    stall_d = 1'b0;
    wen_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          svc_d   = cpu.rega7[1:0];
          stall_d = 1'b1;
          state_d = WAIT_PRESS;
        end else if (cpu.ecall && cpu.rega7 == 32'd4) begin
          led_d = cpu.rega0[15:0];
        end else if (cpu.ecall && cpu.rega7 == 32'd5) begin
          seg_d = cpu.rega0;
        end
      end
      WAIT_PRESS: begin
        stall_d = 1'b1;
        // A level already high on entry never produces a rise event.
        if (btn_rise) begin
          data_d  = fmt(svc_q, switch_in);
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        stall_d = 1'b1;
        if (!btn_d) begin
          stall_d = 1'b0;
          wen_d   = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      btn_q   <= 1'b0;
      cnt_q   <= '0;
      svc_q   <= 2'd0;
      data_q  <= 32'd0;
      stall_q <= 1'b0;
      wen_q   <= 1'b0;
      led_q   <= 16'd0;
      seg_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      btn_q   <= btn_d;
      cnt_q   <= cnt_d;
      svc_q   <= svc_d;
      data_q  <= data_d;
      stall_q <= stall_d;
      wen_q   <= wen_d;
      led_q   <= led_d;
      seg_q   <= seg_d;
    end
  end

  assign cpu.stall    = stall_q | rd_req;
  assign cpu.io_wen   = wen_q;
  assign cpu.io_wdata = data_q;
  assign led_out      = led_q;
  assign seg_out      = seg_q;
endmodule

// File: tb/tb_ecall_io_ctrl.sv
// Bench for ecall_io_ctrl: directed scenarios plus random traffic against a
// transaction-level reference model, with every output compared each cycle.
module tb_ecall_io_ctrl;
  localparam int DC = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] switch_in;
  logic        confirm_btn;
  logic [15:0] led_out;
  logic [31:0] seg_out;

  ecall_io_ctrl_if cpu();

  ecall_io_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
    .clock(clock), .reset(reset), .cpu(cpu), .switch_in(switch_in),
    .confirm_btn(confirm_btn), .led_out(led_out), .seg_out(seg_out)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int wen_cnt = 0;

  // Reference model: phase 0 free, 1 awaiting press, 2 awaiting release, 3 commit.
  int          phase;
  int          m_svc;
  logic [31:0] m_data;
  logic [15:0] m_led;
  logic [31:0] m_seg;
  bit          m_acc;
  bit          dly[$];
  bit          smp[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_fmt(input int svc, input logic [15:0] sw);
    case (svc)
      0:       return 32'(sw);
      1:       return 32'($signed(sw));
      2:       return 32'(sw % 16'd256);
      default: return 32'(sw % 16'd2);
    endcase
  endfunction

  task automatic model_reset();
    phase = 0; m_svc = 0; m_data = '0; m_led = '0; m_seg = '0; m_acc = 1'b0;
    dly.delete(); dly.push_back(1'b0); dly.push_back(1'b0);
    smp.delete();
  endtask

  task automatic model_edge();
    bit s, all_new, rise, fall;
    if (reset) begin model_reset(); return; end
    s = dly.pop_front();
    dly.push_back(confirm_btn);
    smp.push_back(s);
    if (smp.size() > DC) void'(smp.pop_front());
    rise = 1'b0; fall = 1'b0;
    if (smp.size() == DC) begin
      all_new = 1'b1;
      foreach (smp[i]) if (smp[i] == m_acc) all_new = 1'b0;
      if (all_new) begin
        m_acc = !m_acc; rise = m_acc; fall = !m_acc;
        smp.delete();
      end
    end
    case (phase)
      0: if (cpu.ecall) begin
        if (cpu.rega7 < 4)       begin m_svc = int'(cpu.rega7); phase = 1; end
        else if (cpu.rega7 == 4) m_led = cpu.rega0[15:0];
        else if (cpu.rega7 == 5) m_seg = cpu.rega0;
      end
      1: if (rise) begin m_data = ref_fmt(m_svc, switch_in); phase = 2; end
      2: if (fall) phase = 3;
      default: phase = 0;
    endcase
  endtask

  task automatic check_outputs();
    logic exp_stall;
    exp_stall = (phase == 1) || (phase == 2) || (phase == 0 && cpu.ecall === 1'b1 && cpu.rega7 < 4);
    chk("stall",    32'(cpu.stall),  32'(exp_stall));
    chk("io_wen",   32'(cpu.io_wen), 32'(phase == 3));
    chk("io_wdata", cpu.io_wdata,    m_data);
    chk("led_out",  32'(led_out),    32'(m_led));
    chk("seg_out",  seg_out,         m_seg);
    if (cpu.io_wen === 1'b1) wen_cnt++;
  endtask

  task automatic tick();
    @(negedge clock); check_outputs();
    @(posedge clock); model_edge();
    #1;
  endtask

  task automatic btn_hold(input bit lvl, input int n);
    confirm_btn = lvl;
    repeat (n) tick();
  endtask

  task automatic start_read(input int svc, input logic [15:0] sw);
    cpu.ecall = 1'b1; cpu.rega7 = 32'(svc); switch_in = sw;
    tick();
    cpu.ecall = 1'b0;
  endtask

  task automatic dir_read(input string tag, input int svc, input logic [15:0] sw, input logic [31:0] exp);
    int w0;
    w0 = wen_cnt;
    start_read(svc, sw);
    btn_hold(1'b1, 8);
    btn_hold(1'b0, 8);
    chk({tag, "_data"}, cpu.io_wdata, exp);
    chk({tag, "_wen"}, 32'(wen_cnt - w0), 32'd1);
  endtask

  task automatic dir_write(input int svc, input logic [31:0] val);
    cpu.ecall = 1'b1; cpu.rega7 = 32'(svc); cpu.rega0 = val;
    #1;
    chk("wr_stall", 32'(cpu.stall), 32'd0);
    tick();
    cpu.ecall = 1'b0;
    tick();
  endtask

  task automatic rand_read(input bit abort);
    int  seg_left, n, abort_at;
    bit  lvl, seen, aborted;
    seg_left = 0; n = 0; seen = 0; aborted = 0;
    lvl = confirm_btn;
    abort_at = $urandom_range(2, 30);
    cpu.ecall = 1'b1; cpu.rega7 = $urandom_range(0, 3); cpu.rega0 = $urandom;
    switch_in = 16'($urandom);
    tick();
    while (!seen && !aborted && n < 400) begin
      if (seg_left == 0) begin lvl = !lvl; seg_left = $urandom_range(1, 8); end
      confirm_btn = lvl; seg_left--;
      cpu.ecall = 1'($urandom_range(0, 1)); cpu.rega7 = $urandom_range(0, 9);
      cpu.rega0 = $urandom; switch_in = 16'($urandom);
      if (abort && n == abort_at) begin reset = 1'b1; aborted = 1'b1; end
      tick();
      reset = 1'b0; n++;
      seen = (cpu.io_wen === 1'b1);
    end
    cpu.ecall = 1'b0;
    if (aborted) begin
      #1;
      chk("abort_stall", 32'(cpu.stall), 32'd0);
    end else begin
      chk("rd_complete", 32'(seen), 32'd1);
      tick();
    end
  endtask

  task automatic rand_write();
    cpu.ecall = 1'b1; cpu.rega7 = $urandom_range(4, 9); cpu.rega0 = $urandom;
    switch_in = 16'($urandom);
    tick();
    cpu.ecall = 1'b0;
    tick();
  endtask

  initial begin
    int w0, r;
    reset = 1'b1; cpu.ecall = 1'b0; cpu.rega7 = '0; cpu.rega0 = '0;
    switch_in = '0; confirm_btn = 1'b0;
    @(posedge clock); model_reset(); #1;
    tick();
    chk("rst_stall",  32'(cpu.stall),  32'd0);
    chk("rst_wen",    32'(cpu.io_wen), 32'd0);
    chk("rst_wdata",  cpu.io_wdata,    32'd0);
    chk("rst_led",    32'(led_out),    32'd0);
    chk("rst_seg",    seg_out,         32'd0);
    reset = 1'b0;
    tick();

    dir_read("r0", 0, 16'h8001, 32'h0000_8001);
    dir_read("r1", 1, 16'h8001, 32'hFFFF_8001);
    dir_read("r2", 2, 16'h8001, 32'h0000_0001);
    dir_read("r3", 3, 16'h0002, 32'h0000_0000);

    // Bouncing button: only the final sustained high is accepted.
    w0 = wen_cnt;
    start_read(0, 16'h1234);
    repeat (5) begin btn_hold(1'b1, 2); btn_hold(1'b0, 2); end
    chk("bounce_stall", 32'(cpu.stall), 32'd1);
    btn_hold(1'b1, 5);
    chk("bounce_early", cpu.io_wdata, 32'd0);
    tick();
    chk("bounce_cap", cpu.io_wdata, 32'h0000_1234);
    btn_hold(1'b0, 8);
    chk("bounce_wen", 32'(wen_cnt - w0), 32'd1);

    // Button already held when the ecall arrives.
    w0 = wen_cnt;
    btn_hold(1'b1, 8);
    start_read(0, 16'h00AA);
    btn_hold(1'b1, 8);
    chk("held_stall", 32'(cpu.stall), 32'd1);
    chk("held_nocap", cpu.io_wdata, 32'h0000_1234);
    btn_hold(1'b0, 8);
    chk("held_rel_stall", 32'(cpu.stall), 32'd1);
    switch_in = 16'h0F0F;
    btn_hold(1'b1, 8);
    switch_in = 16'hFFFF;
    btn_hold(1'b0, 8);
    chk("held_data", cpu.io_wdata, 32'h0000_0F0F);
    chk("held_wen", 32'(wen_cnt - w0), 32'd1);

    dir_write(4, 32'h1234_ABCD);
    chk("led_wr", 32'(led_out), 32'h0000_ABCD);
    dir_write(5, 32'h1234_ABCD);
    chk("seg_wr", seg_out, 32'h1234_ABCD);
    dir_write(9, 32'hFFFF_FFFF);
    chk("nop_led", 32'(led_out), 32'h0000_ABCD);
    chk("nop_seg", seg_out, 32'h1234_ABCD);

    // Reset in the middle of a read aborts it.
    w0 = wen_cnt;
    start_read(2, 16'h00FF);
    btn_hold(1'b1, 8);
    chk("mid_stall", 32'(cpu.stall), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abrt_stall", 32'(cpu.stall),  32'd0);
    chk("abrt_wen",   32'(cpu.io_wen), 32'd0);
    chk("abrt_led",   32'(led_out),    32'd0);
    chk("abrt_seg",   seg_out,         32'd0);
    btn_hold(1'b0, 8);
    chk("abrt_nowen", 32'(wen_cnt - w0), 32'd0);

    repeat (150) begin
      r = $urandom_range(0, 99);
      if (r < 45)      rand_read(1'b0);
      else if (r < 55) rand_read(1'b1);
      else             rand_write();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
